// File: rtl/puc_pkg.sv
// Shared flow-control definitions for the decoder and the PC/stack unit.
// Opcodes, the control-vector bundle and the four legal vectors.
package puc_pkg;

   localparam logic [3:0] JMP     = 4'h1;
   localparam logic [3:0] IF0JUMP = 4'h2;
   localparam logic [3:0] IF1JUMP = 4'h3;
   localparam logic [3:0] CALL    = 4'h4;
   localparam logic [3:0] CAL0    = 4'h5;
   localparam logic [3:0] CAL1    = 4'h6;
   localparam logic [3:0] RET     = 4'h7;
   localparam logic [3:0] RET0    = 4'h8;
   localparam logic [3:0] RET1    = 4'h9;

   typedef struct packed {
      logic push;
      logic pop;
      logic jmp;
      logic cal;
      logic ret;
   } flow_ctrl_t;

   localparam flow_ctrl_t FC_SEQ  = 5'b00000;
   localparam flow_ctrl_t FC_JUMP = 5'b00100;
   localparam flow_ctrl_t FC_CALL = 5'b10110;
   localparam flow_ctrl_t FC_RET  = 5'b01001;

   function automatic logic fc_legal(flow_ctrl_t f);
      return (f == FC_SEQ) || (f == FC_JUMP) ||
             (f == FC_CALL) || (f == FC_RET);
   endfunction

endpackage

// File: rtl/return_stack.sv
// Return-address LIFO with a combinational top-of-stack read, so a
// value pushed in one cycle can be popped in the very next one.
module return_stack
   import puc_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 5,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_en,
   input  logic             pop_en,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] top,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [CW-1:0]    r_count;
   logic [AW-1:0]    w_wr_idx;
   logic [AW-1:0]    w_rd_idx;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_wr_idx  = r_count[AW-1:0];
   assign w_rd_idx  = AW'(r_count - CW'(1));
   assign full      = (r_count == CW'(DEPTH));
   assign empty     = (r_count == '0);
   assign w_do_push = push_en & ~full;
   assign w_do_pop  = pop_en & ~empty;
   assign count     = r_count;
   // Empty stack reads as zero so no unwritten entry ever reaches pc.
   assign top       = empty ? '0 : r_mem[w_rd_idx];

   // Occupancy counter; a simultaneous push and pop cancel out.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (w_do_push && !w_do_pop) begin
         r_count <= r_count + CW'(1);
      end else if (w_do_pop && !w_do_push) begin
         r_count <= r_count - CW'(1);
      end
   end

   // Entry storage; no reset, writes suppressed while in reset.
   always_ff @(posedge clk) begin
      if (rst_n && w_do_push) begin
         r_mem[w_wr_idx] <= wdata;
      end
   end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter and call/return sequencing with sticky error flags.
// Closes the fetch -> decode -> PC loop at one instruction per cycle.
module pc_stack_unit
   import puc_pkg::*;
#(
   parameter int PC_WIDTH        = 5,
   parameter int INSTR_ADDR_SIZE = 5,
   parameter int STACK_DEPTH     = 8,
   parameter int SP_WIDTH        = $clog2(STACK_DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       stall,
   input  logic                       jmp,
   input  logic                       cal,
   input  logic                       ret,
   input  logic                       push,
   input  logic                       pop,
   input  logic [INSTR_ADDR_SIZE-1:0] jmp_addr,
   output logic [PC_WIDTH-1:0]        pc,
   output logic [SP_WIDTH-1:0]        sp,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow,
   output logic                       underflow,
   output logic                       proto_err
);

   flow_ctrl_t          w_fc;
   logic [PC_WIDTH-1:0] r_pc;
   logic [PC_WIDTH-1:0] w_pc_inc;
   logic [PC_WIDTH-1:0] w_pc_nxt;
   logic [PC_WIDTH-1:0] w_target;
   logic [PC_WIDTH-1:0] w_top;
   logic                w_push;
   logic                w_pop;
   logic                w_set_ovf;
   logic                w_set_unf;
   logic                w_full;
   logic                w_empty;
   logic                r_ovf;
   logic                r_unf;
   logic                r_perr;

   assign w_fc     = {push, pop, jmp, cal, ret};
   assign w_pc_inc = r_pc + PC_WIDTH'(1);
   assign w_target = PC_WIDTH'(jmp_addr);

   // Action by priority RET > CALL > JUMP > SEQ from ret/cal/jmp only.
   always_comb begin
      w_pc_nxt  = w_pc_inc;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_set_ovf = 1'b0;
      w_set_unf = 1'b0;
      if (w_fc.ret) begin
         if (!w_empty) begin
            w_pop    = 1'b1;
            w_pc_nxt = w_top;
         end else begin
            w_set_unf = 1'b1;
         end
      end else if (w_fc.cal) begin
         w_pc_nxt = w_target;
         if (!w_full) w_push = 1'b1;
         else         w_set_ovf = 1'b1;
      end else if (w_fc.jmp) begin
         w_pc_nxt = w_target;
      end
   end

   return_stack #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (PC_WIDTH),
      .CW    (SP_WIDTH)
   ) u_stack (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_en (w_push & ~stall),
      .pop_en  (w_pop & ~stall),
      .wdata   (w_pc_inc),
      .top     (w_top),
      .count   (sp),
      .full    (w_full),
      .empty   (w_empty)
   );

   // PC register and sticky flags; stall freezes everything.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc   <= '0;
         r_ovf  <= 1'b0;
         r_unf  <= 1'b0;
         r_perr <= 1'b0;
      end else if (!stall) begin
         r_pc   <= w_pc_nxt;
         r_ovf  <= r_ovf | w_set_ovf;
         r_unf  <= r_unf | w_set_unf;
         r_perr <= r_perr | ~fc_legal(w_fc);
      end
   end

   assign pc        = r_pc;
   assign full      = w_full;
   assign empty     = w_empty;
   assign overflow  = r_ovf;
   assign underflow = r_unf;
   assign proto_err = r_perr;

endmodule
